// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed hex display driver with frame-aligned loads
// ports: wb_clk_i/wb_rst_i clock and sync active-high reset; enable runs the scan;
//   load_valid/load_ready/load_data/load_dp shadow-register load port;
//   seg_o/dp_o/dig_o registered segment, point and digit drives; frame_done wrap pulse
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int COMMON_ANODE = 0,
  parameter int LEAD_BLANK = 1
) (
`ifdef USE_POWER_PINS
  inout wire vdd,
  inout wire vss,
`endif
  input logic wb_clk_i,
  input logic wb_rst_i,
  input logic enable,
  input logic load_valid,
  output logic load_ready,
  input logic [4*NUM_DIGITS-1:0] load_data,
  input logic [NUM_DIGITS-1:0] load_dp,
  output logic [6:0] seg_o,
  output logic dp_o,
  output logic [NUM_DIGITS-1:0] dig_o,
  output logic frame_done
);
  localparam int PW = $clog2(PRESCALE);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int W = 4 * NUM_DIGITS;
  localparam logic POL = COMMON_ANODE != 0;
  localparam logic [PW-1:0] PC_MAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] D_MAX = DW'(NUM_DIGITS - 1);
  // gfedcba patterns for F..0, digit 0 in the low 7 bits
  localparam logic [111:0] LUT = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                  7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [W-1:0] disp_data, shadow_data, upper;
  logic [NUM_DIGITS-1:0] disp_dp, shadow_dp, dig_on;
  logic pending, active, slot_end, wrap, accept, xfer, lz;
  logic [PW-1:0] pc;
  logic [DW-1:0] d;
  logic [3:0] nib;
  logic [6:0] seg_ah;
  assign load_ready = !pending;
  always_comb begin
    slot_end = pc == PC_MAX;
    wrap = enable && slot_end && d == D_MAX;
    accept = load_valid && !pending;
    // while stopped there is no frame to tear, so a pending value lands at once
    xfer = pending && (wrap || !enable);
    active = enable && pc >= PW'(BLANK_CYCLES);
    // current nibble and everything above it; all-zero means a leading zero
    upper = disp_data >> (4 * d);
    nib = upper[3:0];
    lz = LEAD_BLANK != 0 && d != '0 && upper == '0 && !disp_dp[d];
    seg_ah = lz ? 7'h0 : LUT[7*nib +: 7];
    dig_on = active ? NUM_DIGITS'(1) << d : '0;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pc <= '0;
      d <= '0;
      disp_data <= '0;
      disp_dp <= '0;
      shadow_data <= '0;
      shadow_dp <= '0;
      pending <= 1'b0;
      frame_done <= 1'b0;
      seg_o <= {7{POL}};
      dp_o <= POL;
      dig_o <= POL ? '0 : '1;
    end else begin
      pc <= enable && !slot_end ? pc + 1'b1 : '0;
      d <= !enable || wrap ? '0 : slot_end ? d + 1'b1 : d;
      frame_done <= wrap;
      if (xfer) begin
        disp_data <= shadow_data;
        disp_dp <= shadow_dp;
      end
      if (accept) begin
        shadow_data <= load_data;
        shadow_dp <= load_dp;
      end
      pending <= accept || (pending && !xfer);
      seg_o <= active ? seg_ah ^ {7{POL}} : {7{POL}};
      dp_o <= active ? disp_dp[d] ^ POL : POL;
      dig_o <= POL ? dig_on : ~dig_on;
    end
  end
endmodule
